// File: rtl/digit_scan_mux_pkg.sv
// Shared definitions for the digit scan multiplexer.
// Holds the scan FSM state encoding, the blank and anode-off codes, the
// digit count and a helper that sizes the prescaler counter.
package digit_scan_mux_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    GUARD = 1'b1
  } scan_state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] AN_OFF     = 4'b1111;
  localparam int         NUM_DIGITS = 4;

  // Counter width for the larger of the two phase lengths. A phase length
  // of 1 would give a zero-width counter, so the width is clamped to 1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/digit_scan_mux_scan_prescaler.sv
// Terminal-count prescaler for the digit scan FSM.
// Counts 0..term and wraps to 0; tc is high for the single cycle in which
// the count equals term.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   clear  restart the count from 0 on the next edge (phase change)
//   term   terminal count of the current phase
//   tc     high while count == term
module scan_prescaler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] term,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  assign tc = (count == term);

  // Wrapping on tc keeps the count from ever passing the terminal value,
  // even if term shrinks while the count is above it is not possible here
  // because clear accompanies every phase change.
  always_ff @(posedge clk) begin
    if (reset || clear || tc) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/digit_scan_mux.sv
// Four-digit BCD scan multiplexer for a seven-segment display.
// Cycles through digits 0..3, showing each for SCAN_DIV cycles followed by
// GUARD_CYC cycles with all anodes off. New values are captured into a
// pending register and committed to the shadow register only at the frame
// boundary, so a frame never shows a mix of old and new digits.
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   en          display enable; 0 turns all anodes off, scanning continues
//   load_req    single-cycle strobe capturing din
//   din         four BCD digits, [3:0] is digit 0 (rightmost)
//   load_ack    one-cycle pulse when a value is committed to the shadow
//   frame_tick  one-cycle pulse on the digit 3 -> digit 0 wrap
//   digit_out   BCD code of the displayed digit, 4'hF means blank
//   an          active-low anode enables, an[k] selects digit k
//
// state | meaning
// ------+-------------------------------------------------------------
// SHOW  | anode of digit idx is on for SCAN_DIV cycles
// GUARD | all anodes off for GUARD_CYC cycles, then advance idx
module digit_scan_mux
  import digit_scan_mux_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD_CYC = 16,
  parameter int LZ_BLANK  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load_req,
  input  logic [15:0] din,
  output logic        load_ack,
  output logic        frame_tick,
  output logic [3:0]  digit_out,
  output logic [3:0]  an
);

  localparam int CW = cnt_width(SCAN_DIV, GUARD_CYC);
  localparam logic [CW-1:0] SHOW_TERM  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_TERM = CW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);

  scan_state_t state_q, state_d;
  logic [1:0]  idx_q;
  logic [15:0] shadow_q;
  logic [15:0] pending_q;
  logic        pending_valid_q;
  logic        tc;
  logic        advance;
  logic        frame_adv;
  logic [CW-1:0] term;
  logic [NUM_DIGITS-1:0] blank;
  logic [3:0]  shadow_digit;

  assign term = (state_q == GUARD) ? GUARD_TERM : SHOW_TERM;

  scan_prescaler #(
    .WIDTH (CW)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (state_d != state_q),
    .term  (term),
    .tc    (tc)
  );

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    case (state_q)
      SHOW: begin
        if (tc) begin
          if (GUARD_CYC > 0) begin
            state_d = GUARD;
          end else begin
            advance = 1'b1;
          end
        end
      end
      GUARD: begin
        if (tc) begin
          state_d = SHOW;
          advance = 1'b1;
        end
      end
      default: state_d = SHOW;
    endcase
  end

  assign frame_adv  = advance && (idx_q == 2'd3);
  // Gated by reset so the strobes read 0 while reset is held, whatever
  // the parameterisation does to tc.
  assign frame_tick = frame_adv & ~reset;
  assign load_ack   = frame_adv & (load_req | pending_valid_q) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= SHOW;
      idx_q           <= 2'd0;
      shadow_q        <= 16'h0000;
      pending_q       <= 16'h0000;
      pending_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (advance) begin
        idx_q <= idx_q + 2'd1;
      end
      // A load arriving on the boundary itself is newer than anything
      // pending, so it goes straight to the shadow register.
      if (frame_adv && load_req) begin
        shadow_q        <= din;
        pending_valid_q <= 1'b0;
      end else if (frame_adv && pending_valid_q) begin
        shadow_q        <= pending_q;
        pending_valid_q <= 1'b0;
      end else if (load_req) begin
        pending_q       <= din;
        pending_valid_q <= 1'b1;
      end
    end
  end

  // Digit k blanks only when it and every digit to its left are zero.
  always_comb begin
    blank = '0;
    if (LZ_BLANK != 0) begin
      blank[3] = (shadow_q[15:12] == 4'h0);
      blank[2] = blank[3] && (shadow_q[11:8] == 4'h0);
      blank[1] = blank[2] && (shadow_q[7:4] == 4'h0);
    end
  end

  assign shadow_digit = shadow_q[4*idx_q +: 4];

  // digit_out keeps its last value while anodes are off so the decoder
  // input does not toggle during the guard interval.
  always_ff @(posedge clk) begin
    if (reset) begin
      an        <= AN_OFF;
      digit_out <= 4'h0;
    end else if ((state_q == SHOW) && en) begin
      an        <= ~(4'b0001 << idx_q);
      digit_out <= blank[idx_q] ? BLANK_CODE : shadow_digit;
    end else begin
      an <= AN_OFF;
    end
  end

endmodule

// File: tb/tb_digit_scan_mux.sv
module tb_digit_scan_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic        load_req = 1'b0;
  logic [15:0] din = 16'h0000;

  logic        load_ack, frame_tick;
  logic [3:0]  digit_out, an;
  logic        ack_nz, tick_nz;
  logic [3:0]  digit_nz, an_nz;

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt  = 0;
  int a0;

  always #5 clk = ~clk;

  digit_scan_mux #(
    .SCAN_DIV  (4),
    .GUARD_CYC (1),
    .LZ_BLANK  (1)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load_req   (load_req),
    .din        (din),
    .load_ack   (load_ack),
    .frame_tick (frame_tick),
    .digit_out  (digit_out),
    .an         (an)
  );

  digit_scan_mux #(
    .SCAN_DIV  (4),
    .GUARD_CYC (1),
    .LZ_BLANK  (0)
  ) u_dut_nz (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load_req   (load_req),
    .din        (din),
    .load_ack   (ack_nz),
    .frame_tick (tick_nz),
    .digit_out  (digit_nz),
    .an         (an_nz)
  );

  always @(negedge clk) begin
    #2;
    if (load_ack === 1'b1) ack_cnt++;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load_req = 1'b1;
    din      = v;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic sync_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 60);
    check_eq("sync_frame", 16'(frame_tick), 16'h1);
  endtask

  // Starts on a frame_tick cycle and walks the next 20 cycles, ending on
  // the following frame_tick. Outputs lag the FSM by one cycle, so the
  // first sample of each 5-cycle digit slot is the guard (anodes off).
  task automatic scan_frame(input logic [15:0] exp_lz, input logic [15:0] exp_nz,
                            input logic on);
    logic [3:0] exp_an;
    int ph, k;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      ph = (i - 1) % 5;
      k  = (i - 1) / 5;
      exp_an = (ph == 0 || !on) ? 4'b1111 : ~(4'b0001 << k);
      check_eq("an", 16'(an), 16'(exp_an));
      check_eq("an_nz", 16'(an_nz), 16'(exp_an));
      if (on && ph != 0) begin
        check_eq("digit", 16'(digit_out), 16'(exp_lz[4*k +: 4]));
        check_eq("digit_nz", 16'(digit_nz), 16'(exp_nz[4*k +: 4]));
      end
      if (on && ph == 0 && i > 1) begin
        check_eq("digit_hold", 16'(digit_out), 16'(exp_lz[4*(k-1) +: 4]));
      end
      check_eq("frame_tick", 16'(frame_tick), 16'(i == 20));
      check_eq("frame_tick_nz", 16'(tick_nz), 16'(i == 20));
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_an", 16'(an), 16'hF);
    check_eq("rst_digit", 16'(digit_out), 16'h0);
    check_eq("rst_ack", 16'(load_ack), 16'h0);
    check_eq("rst_tick", 16'(frame_tick), 16'h0);
    check_eq("rst_an_nz", 16'(an_nz), 16'hF);
    check_eq("rst_digit_nz", 16'(digit_nz), 16'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    check_reset_outputs();

    // Load during the very first frame; committed at the first boundary.
    reset = 1'b0;
    pulse_load(16'h1234);
    sync_frame();
    check_eq("ack_1234", 16'(load_ack), 16'h1);
    check_eq("ack_1234_nz", 16'(ack_nz), 16'h1);
    scan_frame(16'h1234, 16'h1234, 1'b1);
    scan_frame(16'h1234, 16'h1234, 1'b1);

    // Leading-zero blanking against the unblanked instance.
    step(3);
    pulse_load(16'h0007);
    sync_frame();
    check_eq("ack_0007", 16'(load_ack), 16'h1);
    scan_frame(16'hFFF7, 16'h0007, 1'b1);

    step(3);
    pulse_load(16'h0000);
    sync_frame();
    check_eq("ack_0000", 16'(load_ack), 16'h1);
    scan_frame(16'hFFF0, 16'h0000, 1'b1);

    step(3);
    pulse_load(16'h1000);
    sync_frame();
    check_eq("ack_1000", 16'(load_ack), 16'h1);
    scan_frame(16'h1000, 16'h1000, 1'b1);

    // Second load before commit overwrites pending; one ack only.
    a0 = ack_cnt;
    step(3);
    pulse_load(16'h1111);
    step(1);
    pulse_load(16'h2222);
    sync_frame();
    check_eq("ack_2222", 16'(load_ack), 16'h1);
    scan_frame(16'h2222, 16'h2222, 1'b1);
    check_eq("ack_count_overwrite", 16'(ack_cnt - a0), 16'h1);

    // Load on the boundary cycle bypasses pending.
    a0 = ack_cnt;
    load_req = 1'b1;
    din      = 16'h5678;
    #1;
    check_eq("ack_bypass", 16'(load_ack), 16'h1);
    check_eq("ack_bypass_nz", 16'(ack_nz), 16'h1);
    @(posedge clk);
    #1;
    load_req = 1'b0;
    scan_frame(16'h5678, 16'h5678, 1'b1);
    check_eq("ack_at_next_tick", 16'(load_ack), 16'h0);
    check_eq("ack_count_bypass", 16'(ack_cnt - a0), 16'h1);

    // Display disabled for one frame; ticks keep coming.
    en = 1'b0;
    scan_frame(16'h5678, 16'h5678, 1'b0);
    en = 1'b1;
    scan_frame(16'h5678, 16'h5678, 1'b1);

    // Reset mid-SHOW with a load pending: discarded, no ack afterwards.
    a0 = ack_cnt;
    step(3);
    pulse_load(16'h9999);
    reset = 1'b1;
    step(2);
    check_reset_outputs();
    reset = 1'b0;
    sync_frame();
    check_eq("ack_after_reset", 16'(load_ack), 16'h0);
    scan_frame(16'hFFF0, 16'h0000, 1'b1);
    check_eq("ack_count_reset", 16'(ack_cnt - a0), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
